// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide memory port arbiter.
//   arb_state_e : FSM state encoding (ARB_IDLE / ARB_READ / ARB_WRITE)
//   SIZE_*      : LSB access size codes (3 is treated as a word)
//   IO_SEL      : value of the two address bits that select the IO region
//   TRUE/FALSE  : 1-bit constants
//   size_bytes(): number of bytes moved for a size code
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [1:0] IO_SEL = 2'b11;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter for the single byte-wide RAM/IO port, shared by the instruction
// fetcher (32-bit reads) and the LSB (1/2/4-byte loads and stores).
// Every granted request becomes a little-endian, one-byte-per-cycle transaction.
//
// Ports
//   in_clk, in_rst_n          clock, async active-low reset
//   in_rdy                    0 freezes every register; out_ram_wr forced low
//   in_flush_enable           aborts reads in flight, blocks a grant in IDLE
//   in_fetch_req/addr         fetch request (level, held until done)
//   out_fetch_done/data       1-cycle done pulse with the instruction word
//   in_lsb_req/we/addr/size/wdata   LSB request (level, held until done)
//   out_lsb_done/rdata        1-cycle done pulse, load data zero-filled
//   in_io_buffer_full         IO write FIFO full: stalls IO-region store bytes
//   in_ram_din                RAM read byte, one cycle after the address
//   out_ram_dout/addr/wr      RAM write byte, byte address, write strobe
//   out_busy                  FSM not in IDLE
//
// Build option
//   MEM_ARB_FAIR_EN : when defined, a last-grant pointer breaks ties in favour
//                     of the requester not served last (LSB wins the first tie).
//                     Otherwise the LSB always has priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IO_SEL_HI = 17
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_rdy,
    input  logic              in_flush_enable,
    input  logic              in_fetch_req,
    input  logic [ADDR_W-1:0] in_fetch_addr,
    output logic              out_fetch_done,
    output logic [31:0]       out_fetch_data,
    input  logic              in_lsb_req,
    input  logic              in_lsb_we,
    input  logic [ADDR_W-1:0] in_lsb_addr,
    input  logic [1:0]        in_lsb_size,
    input  logic [31:0]       in_lsb_wdata,
    output logic              out_lsb_done,
    output logic [31:0]       out_lsb_rdata,
    input  logic              in_io_buffer_full,
    input  logic [7:0]        in_ram_din,
    output logic [7:0]        out_ram_dout,
    output logic [ADDR_W-1:0] out_ram_addr,
    output logic              out_ram_wr,
    output logic              out_busy
);

    arb_state_e        state_q;
    logic [2:0]        cnt_q;       // read: cycles since grant; write: byte on the bus
    logic [2:0]        nbytes_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic              own_lsb_q;
    logic [31:0]       asm_q;       // read byte assembly
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_dout_q;
    logic              ram_wr_q;
    logic              fetch_done_q;
    logic [31:0]       fetch_data_q;
    logic              lsb_done_q;
    logic [31:0]       lsb_rdata_q;
`ifdef MEM_ARB_FAIR_EN
    logic              last_lsb_q;  // 1 = LSB was granted last
`endif

    logic              pick_lsb_d;
    logic              grant_d;
    logic              g_we_d;
    logic [ADDR_W-1:0] g_addr_d;
    logic [2:0]        g_nbytes_d;
    logic [2:0]        rd_nxt_d;
    logic [2:0]        wr_nxt_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [1:0]        asm_idx_d;

    function automatic logic in_io(input logic [ADDR_W-1:0] a);
        return a[IO_SEL_HI -: 2] == IO_SEL;
    endfunction

    always_comb begin
`ifdef MEM_ARB_FAIR_EN
        pick_lsb_d = in_lsb_req & (~in_fetch_req | ~last_lsb_q);
`else
        pick_lsb_d = in_lsb_req;
`endif
        // A done pulse is still high during the one IDLE cycle that follows
        // completion; no grant then, so the requester can drop its request.
        grant_d    = (in_lsb_req | in_fetch_req) & ~in_flush_enable
                     & ~fetch_done_q & ~lsb_done_q;
        g_we_d     = pick_lsb_d & in_lsb_we;
        g_addr_d   = pick_lsb_d ? in_lsb_addr : in_fetch_addr;
        g_nbytes_d = pick_lsb_d ? size_bytes(in_lsb_size) : 3'd4;
        rd_nxt_d   = cnt_q + 3'd1;
        // A stalled byte (strobe low) is re-presented instead of advancing.
        wr_nxt_d   = ram_wr_q ? cnt_q + 3'd1 : cnt_q;
        wr_addr_d  = base_q + ADDR_W'(wr_nxt_d);
        asm_idx_d  = 2'(cnt_q - 3'd1);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q      <= ARB_IDLE;
            cnt_q        <= '0;
            nbytes_q     <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            own_lsb_q    <= FALSE;
            asm_q        <= '0;
            ram_addr_q   <= '0;
            ram_dout_q   <= '0;
            ram_wr_q     <= FALSE;
            fetch_done_q <= FALSE;
            fetch_data_q <= '0;
            lsb_done_q   <= FALSE;
            lsb_rdata_q  <= '0;
`ifdef MEM_ARB_FAIR_EN
            last_lsb_q   <= FALSE;
`endif
        end else if (in_rdy) begin
            fetch_done_q <= FALSE;
            lsb_done_q   <= FALSE;
            case (state_q)
                ARB_IDLE: begin
                    if (grant_d) begin
                        own_lsb_q  <= pick_lsb_d;
                        base_q     <= g_addr_d;
                        nbytes_q   <= g_nbytes_d;
                        wdata_q    <= in_lsb_wdata;
                        cnt_q      <= '0;
                        asm_q      <= '0;
                        ram_addr_q <= g_addr_d;
`ifdef MEM_ARB_FAIR_EN
                        last_lsb_q <= pick_lsb_d;
`endif
                        if (g_we_d) begin
                            state_q    <= ARB_WRITE;
                            ram_dout_q <= in_lsb_wdata[7:0];
                            ram_wr_q   <= ~(in_io(g_addr_d) & in_io_buffer_full);
                        end else begin
                            state_q  <= ARB_READ;
                            ram_wr_q <= FALSE;
                        end
                    end
                end

                // cnt_q = k: byte k-1 is on in_ram_din (address k-1 went out
                // two edges ago); the extra count registers data with done.
                ARB_READ: begin
                    if (in_flush_enable) begin
                        state_q <= ARB_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == nbytes_q + 3'd1) begin
                        state_q <= ARB_IDLE;
                        cnt_q   <= '0;
                        if (own_lsb_q) begin
                            lsb_done_q  <= TRUE;
                            lsb_rdata_q <= asm_q;
                        end else begin
                            fetch_done_q <= TRUE;
                            fetch_data_q <= asm_q;
                        end
                    end else begin
                        if (cnt_q != 3'd0)
                            asm_q[{asm_idx_d, 3'b000} +: 8] <= in_ram_din;
                        if (rd_nxt_d < nbytes_q)
                            ram_addr_q <= base_q + ADDR_W'(rd_nxt_d);
                        cnt_q <= rd_nxt_d;
                    end
                end

                // Stores are committed, so flush is ignored here.
                ARB_WRITE: begin
                    if (cnt_q == nbytes_q) begin
                        state_q    <= ARB_IDLE;
                        cnt_q      <= '0;
                        lsb_done_q <= TRUE;
                    end else begin
                        cnt_q <= wr_nxt_d;
                        if (wr_nxt_d < nbytes_q) begin
                            ram_addr_q <= wr_addr_d;
                            ram_dout_q <= wdata_q[{wr_nxt_d[1:0], 3'b000} +: 8];
                            ram_wr_q   <= ~(in_io(wr_addr_d) & in_io_buffer_full);
                        end else begin
                            ram_wr_q <= FALSE;
                        end
                    end
                end

                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign out_fetch_done = fetch_done_q;
    assign out_fetch_data = fetch_data_q;
    assign out_lsb_done   = lsb_done_q;
    assign out_lsb_rdata  = lsb_rdata_q;
    assign out_ram_dout   = ram_dout_q;
    assign out_ram_addr   = ram_addr_q;
    assign out_ram_wr     = ram_wr_q & in_rdy;
    assign out_busy       = state_q != ARB_IDLE;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a registered byte RAM model, directed
// scenarios and randomized transactions checked against a transaction-level
// reference (latency by rule, data from the bench memory, grant order).
module tb_mem_arbiter;

    logic        in_clk = 1'b0;
    logic        in_rst_n = 1'b0;
    logic        in_rdy = 1'b1;
    logic        in_flush_enable = 1'b0;
    logic        in_fetch_req = 1'b0;
    logic [31:0] in_fetch_addr = '0;
    logic        out_fetch_done;
    logic [31:0] out_fetch_data;
    logic        in_lsb_req = 1'b0;
    logic        in_lsb_we = 1'b0;
    logic [31:0] in_lsb_addr = '0;
    logic [1:0]  in_lsb_size = '0;
    logic [31:0] in_lsb_wdata = '0;
    logic        out_lsb_done;
    logic [31:0] out_lsb_rdata;
    logic        in_io_buffer_full = 1'b0;
    logic [7:0]  in_ram_din = '0;
    logic [7:0]  out_ram_dout;
    logic [31:0] out_ram_addr;
    logic        out_ram_wr;
    logic        out_busy;

    mem_arbiter dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_rdy(in_rdy),
        .in_flush_enable(in_flush_enable),
        .in_fetch_req(in_fetch_req), .in_fetch_addr(in_fetch_addr),
        .out_fetch_done(out_fetch_done), .out_fetch_data(out_fetch_data),
        .in_lsb_req(in_lsb_req), .in_lsb_we(in_lsb_we), .in_lsb_addr(in_lsb_addr),
        .in_lsb_size(in_lsb_size), .in_lsb_wdata(in_lsb_wdata),
        .out_lsb_done(out_lsb_done), .out_lsb_rdata(out_lsb_rdata),
        .in_io_buffer_full(in_io_buffer_full), .in_ram_din(in_ram_din),
        .out_ram_dout(out_ram_dout), .out_ram_addr(out_ram_addr),
        .out_ram_wr(out_ram_wr), .out_busy(out_busy)
    );

    always #5 in_clk = ~in_clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  mem [logic [31:0]];
    logic [39:0] wlog [$];

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    // Registered RAM: the address seen at an edge is answered during the next
    // cycle. It is clocked together with the core, so it also halts on in_rdy=0.
    always @(posedge in_clk) begin
        if (in_rdy) in_ram_din <= rd_mem(out_ram_addr);
        if (out_ram_wr) begin
            mem[out_ram_addr] = out_ram_dout;
            wlog.push_back({out_ram_addr, out_ram_dout});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // One request from idle. rnd: random in_rdy and in_io_buffer_full;
    // full_n: io_full held for the first full_n active edges (grant edge
    // included); flush_t: active-edge index after grant to pulse flush (-1 none).
    task automatic xact(input bit is_lsb, input bit we, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd, input bit rnd,
                        input int full_n, input int flush_t, output logic [31:0] rdat);
        int n, t, j, last_v, t_done, cyc;
        bit rd, aborted, act, full, fl, busy_at_done;
        logic [31:0] exp_d;
        n = is_lsb ? nbytes(sz) : 4;
        rd = !(is_lsb && we);
        t = -1; j = 0; last_v = -1; t_done = -1; cyc = 0;
        aborted = 0; busy_at_done = 0; rdat = '0;
        exp_d = '0;
        for (int i = 0; i < n; i++) exp_d[8*i +: 8] = rd_mem(a + 32'(i));
        wlog.delete();
        if (is_lsb) begin
            in_lsb_req = 1; in_lsb_we = we; in_lsb_addr = a;
            in_lsb_size = sz; in_lsb_wdata = wd;
        end else begin
            in_fetch_req = 1; in_fetch_addr = a;
        end
        while (t_done < 0 && !aborted && cyc < 300) begin
            in_rdy = rnd ? ($urandom_range(7) != 0) : 1'b1;
            in_io_buffer_full = rnd ? ($urandom_range(2) == 0) : (t + 1 < full_n);
            in_flush_enable = (flush_t > 0) && (t + 1 == flush_t);
            @(posedge in_clk);
            act = in_rdy; full = in_io_buffer_full; fl = in_flush_enable;
            #1;
            cyc++;
            if (!act) continue;
            if (t < 0) begin
                chk("grant_first_edge", out_busy, 1);
                t = 0;
            end else t++;
            // store bytes go out in order; an IO byte waits while the FIFO is full
            if (!rd && j < n) begin
                if (!(is_io(a + 32'(j)) && full)) begin
                    j++;
                    last_v = t;
                end
            end
            if (fl && rd) begin
                aborted = 1;
                chk("flush_abort_busy", out_busy, 0);
                chk("flush_abort_nodone", out_fetch_done | out_lsb_done, 0);
            end else if (out_fetch_done || out_lsb_done) begin
                t_done = t;
                busy_at_done = out_busy;
                chk("done_owner", {out_lsb_done, out_fetch_done}, is_lsb ? 2'b10 : 2'b01);
                rdat = is_lsb ? out_lsb_rdata : out_fetch_data;
            end
        end
        in_flush_enable = 0; in_io_buffer_full = 0; in_rdy = 1;
        in_lsb_req = 0; in_fetch_req = 0;
        if (aborted) begin
            bit seen = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                seen |= out_fetch_done | out_lsb_done;
            end
            chk("flush_quiet", seen, 0);
        end else begin
            chk("latency", t_done, rd ? n + 2 : last_v + 2);
            chk("idle_at_done", busy_at_done, 0);
            if (rd) chk("rdata", rdat, exp_d);
            else begin
                chk("wr_count", wlog.size(), n);
                for (int i = 0; i < n && i < wlog.size(); i++)
                    chk("wr_byte", wlog[i], {a + 32'(i), wd[8*i +: 8]});
            end
            tick();
        end
    endtask

    // Both requesters held high: LSB wants nl 1-byte loads at la, fetch wants
    // nf words at fa. Checks grant order, the 1-cycle post-done gap and data.
    task automatic contend(input int nl, input int nf, input logic [31:0] la,
                           input logic [31:0] fa);
        int gl, gf, cyc, last_cyc, rl, rf;
        bit last_l, pl;
        int ord [$];
        int exp_ord [$];
        gl = 0; gf = 0; cyc = 0; last_cyc = 0;
        rl = nl; rf = nf; last_l = 0;
        while (rl > 0 || rf > 0) begin
`ifdef MEM_ARB_FAIR_EN
            pl = (rl > 0) && (rf == 0 || !last_l);
`else
            pl = rl > 0;
`endif
            exp_ord.push_back(pl ? 0 : 1);
            if (pl) rl--; else rf--;
            last_l = pl;
        end
        in_lsb_we = 0; in_lsb_addr = la; in_lsb_size = 2'd0; in_fetch_addr = fa;
        in_lsb_req = (nl > 0); in_fetch_req = (nf > 0);
        while ((gl < nl || gf < nf) && cyc < 400) begin
            tick();
            cyc++;
            if (out_lsb_done || out_fetch_done) begin
                int nb = out_lsb_done ? 1 : 4;
                if (last_cyc == 0) chk("first_done", cyc, nb + 3);
                else chk("gap_delta", cyc - last_cyc, nb + 4);
                last_cyc = cyc;
            end
            if (out_lsb_done) begin
                gl++; ord.push_back(0);
                chk("lsb_zero_fill", out_lsb_rdata, {24'h0, rd_mem(la)});
                if (gl == nl) in_lsb_req = 0;
            end
            if (out_fetch_done) begin
                gf++; ord.push_back(1);
                chk("fetch_data", out_fetch_data,
                    {rd_mem(fa + 3), rd_mem(fa + 2), rd_mem(fa + 1), rd_mem(fa)});
                if (gf == nf) in_fetch_req = 0;
            end
        end
        in_lsb_req = 0; in_fetch_req = 0;
        chk("ord_len", ord.size(), exp_ord.size());
        for (int i = 0; i < exp_ord.size() && i < ord.size(); i++)
            chk("grant_order", ord[i], exp_ord[i]);
        tick();
    endtask

    initial begin
        logic [31:0] rdat, a;
        mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h05;
        mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h00;

        #12;
        chk("rst_busy", out_busy, 0);
        chk("rst_ram_wr", out_ram_wr, 0);
        chk("rst_ram_addr", out_ram_addr, 0);
        chk("rst_ram_dout", out_ram_dout, 0);
        chk("rst_dones", {out_fetch_done, out_lsb_done}, 0);
        chk("rst_data", {out_fetch_data, out_lsb_rdata}, 0);
        @(negedge in_clk);
        in_rst_n = 1;
        tick();

        xact(0, 0, 32'h1000, 2'd2, 0, 0, 0, -1, rdat);
        chk("fetch_0x1000", rdat, 32'h0000_0513);

        xact(1, 1, 32'h200, 2'd2, 32'hDEAD_BEEF, 0, 0, -1, rdat);
        chk("store_mem", {mem[32'h203], mem[32'h202], mem[32'h201], mem[32'h200]},
            32'hDEAD_BEEF);

        contend(1, 1, 32'h0040, 32'h0080);

        xact(1, 1, 32'h0003_0000, 2'd0, 32'h0000_00A5, 0, 3, -1, rdat);
        xact(1, 1, 32'h0002_FFFE, 2'd2, 32'h1122_3344, 0, 2, -1, rdat);

        xact(0, 0, 32'h1000, 2'd2, 0, 0, 0, 3, rdat);
        xact(0, 0, 32'h1000, 2'd2, 0, 0, 0, 6, rdat);
        xact(1, 0, 32'h0123, 2'd1, 0, 0, 0, 2, rdat);
        xact(1, 1, 32'h300, 2'd2, 32'hCAFE_F00D, 0, 0, 2, rdat);

        in_fetch_req = 1; in_fetch_addr = 32'h2000; in_flush_enable = 1;
        tick();
        chk("flush_idle_nogrant", out_busy, 0);
        in_flush_enable = 0;
        tick();
        chk("grant_after_flush", out_busy, 1);
        in_flush_enable = 1;
        tick();
        in_flush_enable = 0; in_fetch_req = 0;
        chk("abort_after_grant", out_busy, 0);
        tick();

        xact(0, 0, 32'hFFFF_FFFE, 2'd2, 0, 0, 0, -1, rdat);
        xact(1, 0, 32'hFFFF_FFFF, 2'd3, 0, 0, 0, -1, rdat);

        contend(3, 3, 32'h0044, 32'h0100);

        for (int k = 0; k < 60; k++) begin
            bit isl, we;
            logic [1:0] sz;
            int ft;
            isl = $urandom_range(2) != 0;
            we  = $urandom_range(1) != 0;
            sz  = 2'($urandom_range(3));
            case ($urandom_range(2))
                0: a = {16'h0, 16'($urandom)};
                1: a = 32'h0003_0000 | {20'h0, 12'($urandom)};
                default: a = 32'hFFFF_FFFC + 32'($urandom_range(3));
            endcase
            ft = -1;
            if (!(isl && we) && $urandom_range(4) == 0)
                ft = $urandom_range(isl ? nbytes(sz) + 2 : 6, 1);
            xact(isl, we, a, sz, $urandom, 1, 0, ft, rdat);
        end

        // asynchronous reset in the middle of a fetch
        in_fetch_req = 1; in_fetch_addr = 32'h1000;
        tick(); tick();
        #2 in_rst_n = 0;
        #1;
        chk("async_rst_busy", out_busy, 0);
        chk("async_rst_addr", out_ram_addr, 0);
        in_fetch_req = 0;
        @(negedge in_clk);
        in_rst_n = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
